// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Stalls the pipeline while iterating; quotient feeds LO, remainder feeds HI.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic        dvs_zero;

  logic        accept;
  logic        last;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shl;
  logic        fit;
  logic [31:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept = (state == IDLE) && div_start && !div_cancel;
  assign last   = (state == CALC) && (cnt == 6'd31);

  always_comb begin
    a_abs = dividend;
    b_abs = divisor;
    if (div_signed && dividend[31]) a_abs = -dividend;
    if (div_signed && divisor[31])  b_abs = -divisor;
  end

  // Trial result always fits 32 bits when the subtract succeeds.
  assign shl     = {rem, quo[31]};
  assign fit     = shl >= {1'b0, dvs};
  assign diff    = shl[31:0] - dvs;
  assign rem_nxt = fit ? diff : shl[31:0];
  assign quo_nxt = {quo[30:0], fit};

  // With a zero divisor rem_nxt is |dividend|, so restoring its sign
  // hands back the dividend as it was latched.
  always_comb begin
    q_fix = neg_q ? -quo_nxt : quo_nxt;
    r_fix = neg_r ? -rem_nxt : rem_nxt;
    if (dvs_zero) q_fix = 32'hFFFF_FFFF;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (div_cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem      <= '0;
        quo      <= a_abs;
        dvs      <= b_abs;
        cnt      <= '0;
        neg_q    <= div_signed && (dividend[31] ^ divisor[31]);
        neg_r    <= div_signed && dividend[31];
        dvs_zero <= (divisor == 32'd0);
      end else if (state == CALC) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 6'd1;
      end
      if (last && !div_cancel) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

  assign div_done  = (state == DONE) && !div_cancel;
  assign div_stall = !rst && (accept || (state == CALC));

endmodule
